adc_capture_ctrl: RTL

Sequencer for the ADC receive chain. On a start pulse it loads carrier (Fc_scaled) and decimation settings into the chain, enables the ADC front end, and discards DDC output while the filters settle. It then forwards exactly N complex DDC samples downstream on AXI-Stream with tlast on the final one, and disables the ADC. It sits between the PS-side register block and the ADC_Chain wrapper, all in the 100 MHz domain.

---
 rtl/adc_capture_ctrl.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
//
// Purpose:
//   Sequencer for the ADC receive chain. On an accepted start it loads the
//   carrier increment and decimation ratio into the chain and waits two cycles
//   with the front end disabled so the DDS/CIC can reload. It then enables the
//   ADC, discards cfg_settle DDC samples while the filters settle, and forwards
//   exactly cfg_num_samples samples on AXI-Stream with tlast on the final one.
//   Finally it disables the ADC, waits for the output register to drain and
//   pulses done.
//
// Optional build macro:
//   ADC_CAPTURE_TIMEOUT_EN - adds parameter TIMEOUT_CYC and output timeout.
//   While settling or capturing, a watchdog counts cycles since the last DDC
//   beat. When it expires it raises a sticky timeout flag (cleared by the next
//   accepted start), disables the ADC, drops any pending output beat and
//   returns to IDLE without done. Without the macro the controller waits
//   indefinitely for DDC samples.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   start, abort            single-cycle control pulses
//   cfg_*                   capture settings, sampled on an accepted start
//   Fc_scaled               carrier phase increment to the ADC chain
//   decimate_ratio          decimation ratio to the ADC chain (0 becomes 1)
//   ADC_control             ADC_EN_CODE while the chain is enabled, else 0
//   s_axis_tdata/tvalid     DDC output, no backpressure available upstream
//   m_axis_tdata/tvalid/    captured samples downstream, 1-deep output
//   tready/tlast            register, tlast with the final sample
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse when a capture completes
//   drop_cnt                beats lost to a downstream stall (saturating)
//   timeout                 (macro only) sticky watchdog flag
// -----------------------------------------------------------------------------
module adc_capture_ctrl #(
  parameter int          SETTLE_W    = 16,
  parameter int          CNT_W       = 32,
  parameter logic [3:0]  ADC_EN_CODE = 4'b0001
`ifdef ADC_CAPTURE_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC = 65536
`endif
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         cfg_fc_scaled,
  input  logic [15:0]         cfg_decimate,
  input  logic [CNT_W-1:0]    cfg_num_samples,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [31:0]         Fc_scaled,
  output logic [15:0]         decimate_ratio,
  output logic [3:0]          ADC_control,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    drop_cnt
`ifdef ADC_CAPTURE_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    SETTLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t              state_reg, state_next;
  logic [31:0]         fc_reg, fc_next;
  logic [15:0]         dec_reg, dec_next;
  logic [3:0]          adc_reg, adc_next;
  logic [31:0]         tdata_reg, tdata_next;
  logic                tvalid_reg, tvalid_next;
  logic                tlast_reg, tlast_next;
  logic                done_reg, done_next;
  logic [CNT_W-1:0]    drop_reg, drop_next;
  logic [CNT_W-1:0]    num_reg, num_next;
  logic [SETTLE_W-1:0] settle_reg, settle_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [CNT_W-1:0]    sample_cnt_reg, sample_cnt_next;
  logic                cfg_cnt_reg, cfg_cnt_next;
`ifdef ADC_CAPTURE_TIMEOUT_EN
  logic [31:0]         to_cnt_reg, to_cnt_next;
  logic                timeout_reg, timeout_next;
`endif

  logic handshake;
  assign handshake = tvalid_reg && m_axis_tready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    fc_next         = fc_reg;
    dec_next        = dec_reg;
    adc_next        = adc_reg;
    tdata_next      = tdata_reg;
    tvalid_next     = tvalid_reg;
    tlast_next      = tlast_reg;
    done_next       = 1'b0;
    drop_next       = drop_reg;
    num_next        = num_reg;
    settle_next     = settle_reg;
    settle_cnt_next = settle_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    cfg_cnt_next    = cfg_cnt_reg;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    to_cnt_next     = 32'd0;
    timeout_next    = timeout_reg;
`endif

    // A consumed beat empties the output register; a load below overrides.
    if (handshake) begin
      tvalid_next = 1'b0;
      tlast_next  = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        // done_reg high means this is the completion cycle: starts are ignored.
        if (start && !done_reg) begin
          fc_next         = cfg_fc_scaled;
          dec_next        = (cfg_decimate == 16'd0) ? 16'd1 : cfg_decimate;
          num_next        = cfg_num_samples;
          settle_next     = cfg_settle;
          drop_next       = '0;
          settle_cnt_next = '0;
          sample_cnt_next = '0;
          cfg_cnt_next    = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
          timeout_next    = 1'b0;
`endif
          state_next      = CONFIG;
        end
      end

      CONFIG: begin
        // Two cycles with the front end off so the DDS/CIC reload cleanly.
        if (cfg_cnt_reg) begin
          adc_next   = ADC_EN_CODE;
          state_next = SETTLE;
        end else begin
          cfg_cnt_next = 1'b1;
        end
      end

      SETTLE: begin
        if (settle_cnt_reg == settle_reg) begin
          state_next = CAPTURE;
        end else if (s_axis_tvalid) begin
          settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
        end
      end

      CAPTURE: begin
        if (num_reg == '0) begin
          adc_next   = 4'd0;
          state_next = DRAIN;
        end else if (s_axis_tvalid) begin
          if (!tvalid_reg || m_axis_tready) begin
            tdata_next      = s_axis_tdata;
            tvalid_next     = 1'b1;
            sample_cnt_next = sample_cnt_reg + CNT_W'(1);
            if (sample_cnt_reg + CNT_W'(1) == num_reg) begin
              tlast_next = 1'b1;
              adc_next   = 4'd0;
              state_next = DRAIN;
            end else begin
              tlast_next = 1'b0;
            end
          end else if (drop_reg != '1) begin
            drop_next = drop_reg + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (!tvalid_reg || handshake) begin
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

`ifdef ADC_CAPTURE_TIMEOUT_EN
    // Watchdog: cycles since the last DDC beat while samples are expected.
    if (state_reg == SETTLE || state_reg == CAPTURE) begin
      if (s_axis_tvalid) begin
        to_cnt_next = 32'd0;
      end else if (to_cnt_reg == 32'(TIMEOUT_CYC - 1)) begin
        timeout_next = 1'b1;
        adc_next     = 4'd0;
        tvalid_next  = 1'b0;
        tlast_next   = 1'b0;
        state_next   = IDLE;
      end else begin
        to_cnt_next = to_cnt_reg + 32'd1;
      end
    end
`endif

    // Abort wins over everything, including a completing capture.
    if (abort) begin
      adc_next    = 4'd0;
      tvalid_next = 1'b0;
      tlast_next  = 1'b0;
      done_next   = 1'b0;
      state_next  = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      fc_reg         <= 32'd0;
      dec_reg        <= 16'd160;
      adc_reg        <= 4'd0;
      tdata_reg      <= 32'd0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      done_reg       <= 1'b0;
      drop_reg       <= '0;
      num_reg        <= '0;
      settle_reg     <= '0;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
      cfg_cnt_reg    <= 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
      to_cnt_reg     <= 32'd0;
      timeout_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      fc_reg         <= fc_next;
      dec_reg        <= dec_next;
      adc_reg        <= adc_next;
      tdata_reg      <= tdata_next;
      tvalid_reg     <= tvalid_next;
      tlast_reg      <= tlast_next;
      done_reg       <= done_next;
      drop_reg       <= drop_next;
      num_reg        <= num_next;
      settle_reg     <= settle_next;
      settle_cnt_reg <= settle_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
      cfg_cnt_reg    <= cfg_cnt_next;
`ifdef ADC_CAPTURE_TIMEOUT_EN
      to_cnt_reg     <= to_cnt_next;
      timeout_reg    <= timeout_next;
`endif
    end
  end

  assign Fc_scaled      = fc_reg;
  assign decimate_ratio = dec_reg;
  assign ADC_control    = adc_reg;
  assign m_axis_tdata   = tdata_reg;
  assign m_axis_tvalid  = tvalid_reg;
  assign m_axis_tlast   = tlast_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign drop_cnt       = drop_reg;
`ifdef ADC_CAPTURE_TIMEOUT_EN
  assign timeout        = timeout_reg;
`endif

endmodule
